// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings, fetch FSM states and the
// default reset PC.
package cpu_pkg;

  localparam logic [1:0]  PCSRC_SEQ    = 2'b00;
  localparam logic [1:0]  PCSRC_RSV    = 2'b01;
  localparam logic [1:0]  PCSRC_BR     = 2'b10;
  localparam logic [1:0]  PCSRC_JMP    = 2'b11;

  localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'b00,
    IF_FETCH = 2'b01,
    IF_HOLD  = 2'b10
  } if_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC computation: sequential, PC-relative branch or pseudo-direct jump.
// All arithmetic wraps modulo 2^32.
module pc_next
  import cpu_pkg::*;
(
  input  logic [31:0] PC,
  input  logic [31:0] IR,
  input  logic [1:0]  Pcsrc,
  output logic [31:0] next_pc
);

  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic [31:0] w_br_target;
  logic [31:0] w_jmp_target;
  logic        w_unused_ir;

  assign w_pc4        = PC + 32'd4;
  assign w_br_off     = {{14{IR[15]}}, IR[15:0], 2'b00};
  assign w_br_target  = w_pc4 + w_br_off;
  assign w_jmp_target = {w_pc4[31:28], IR[25:0], 2'b00};
  // The opcode field never contributes to the target address.
  assign w_unused_ir  = &{1'b0, IR[31:26]};

  always_comb begin
    next_pc = w_pc4;
    unique case (Pcsrc)
      PCSRC_BR:  next_pc = w_br_target;
      PCSRC_JMP: next_pc = w_jmp_target;
      default:   next_pc = w_pc4;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: requests the word at PC, holds it in IR until the
// core advances, then steps the PC via pc_next.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CPU_RESET_PC
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [1:0]  Pcsrc,
  input  logic        Advance,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  input  logic        Imem_ack,
  input  logic [31:0] Imem_rdata,
  output logic [31:0] Inst,
  output logic [5:0]  Op,
  output logic [5:0]  Func,
  output logic        Inst_valid,
  output logic [31:0] Pc4,
  output logic [31:0] Inst_cnt,
  output if_state_t   Dbg_state
);

  // Handshakes: a fetch completes on any cycle with Imem_req && Imem_ack
  // (including the first request cycle); an instruction retires on any cycle
  // with Inst_valid && Advance. Ack and Advance are ignored otherwise.

  if_state_t   r_state;
  if_state_t   w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_cnt;
  logic [31:0] w_next_pc;
  logic        w_fetch_done;
  logic        w_retire;

  pc_next u_pc_next (
    .PC      (r_pc),
    .IR      (r_ir),
    .Pcsrc   (Pcsrc),
    .next_pc (w_next_pc)
  );

  assign w_fetch_done = (r_state == IF_FETCH) && Imem_ack;
  assign w_retire     = (r_state == IF_HOLD) && Advance;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IF_IDLE:  w_state_nxt = IF_FETCH;
      IF_FETCH: if (Imem_ack) w_state_nxt = IF_HOLD;
      IF_HOLD:  if (Advance)  w_state_nxt = IF_FETCH;
      default:  w_state_nxt = IF_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_state <= IF_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Async reset also kills any fetch in flight, so a late ack cannot load IR.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_pc  <= RESET_PC;
      r_ir  <= 32'd0;
      r_cnt <= 32'd0;
    end else begin
      if (w_fetch_done) begin
        r_ir <= Imem_rdata;
      end
      if (w_retire) begin
        r_pc  <= w_next_pc;
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign Imem_req   = (r_state == IF_FETCH);
  assign Imem_addr  = r_pc;
  assign Inst_valid = (r_state == IF_HOLD);
  assign Inst       = r_ir;
  assign Op         = r_ir[31:26];
  assign Func       = r_ir[5:0];
  assign Pc4        = r_pc + 32'd4;
  assign Inst_cnt   = r_cnt;
  assign Dbg_state  = r_state;

endmodule

// File: tb/tb_if_stage.sv
// Directed plus randomized bench for if_stage against a transaction-level
// model of the fetch/retire behaviour.
module tb_if_stage;
  import cpu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        clrn;
  logic [1:0]  pcsrc;
  logic        advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [5:0]  op;
  logic [5:0]  func;
  logic        inst_valid;
  logic [31:0] pc4;
  logic [31:0] inst_cnt;
  if_state_t   dbg_state;

  int checks = 0;
  int fails  = 0;

  // Reference model state: one entry per architectural quantity.
  logic [31:0] exp_pc;
  logic [31:0] exp_ir;
  logic [31:0] exp_cnt;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .Clk        (clk),
    .Clrn       (clrn),
    .Pcsrc      (pcsrc),
    .Advance    (advance),
    .Imem_req   (imem_req),
    .Imem_addr  (imem_addr),
    .Imem_ack   (imem_ack),
    .Imem_rdata (imem_rdata),
    .Inst       (inst),
    .Op         (op),
    .Func       (func),
    .Inst_valid (inst_valid),
    .Pc4        (pc4),
    .Inst_cnt   (inst_cnt),
    .Dbg_state  (dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  // Architectural next-PC rule, in plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ir,
                                             input logic [1:0] sel);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    if (sel == 2'b10) begin
      off = int'($signed(ir[15:0])) * 4;
      return seq + 32'(off);
    end else if (sel == 2'b11) begin
      return (seq & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) * 32'd4);
    end
    return seq;
  endfunction

  // Driver: FETCH phase, ack withheld for wait_cycles cycles then delivered.
  task automatic fetch(input int wait_cycles, input logic [31:0] word);
    for (int i = 0; i <= wait_cycles; i++) begin
      check("fetch_req",   {31'd0, imem_req},   32'd1);
      check("fetch_addr",  imem_addr,           exp_pc);
      check("fetch_valid", {31'd0, inst_valid}, 32'd0);
      check("fetch_ir",    inst,                exp_ir);
      check("fetch_cnt",   inst_cnt,            exp_cnt);
      advance    = 1'($urandom_range(0, 1));
      pcsrc      = 2'($urandom_range(0, 3));
      imem_ack   = (i == wait_cycles);
      imem_rdata = (i == wait_cycles) ? word : $urandom;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    exp_ir   = word;
  endtask

  // Driver: HOLD phase, Advance withheld for wait_cycles cycles.
  task automatic hold(input int wait_cycles, input logic [1:0] sel, input bit spurious);
    for (int i = 0; i <= wait_cycles; i++) begin
      check("hold_valid", {31'd0, inst_valid}, 32'd1);
      check("hold_req",   {31'd0, imem_req},   32'd0);
      check("hold_ir",    inst,                exp_ir);
      check("hold_op",    {26'd0, op},         {26'd0, exp_ir[31:26]});
      check("hold_func",  {26'd0, func},       {26'd0, exp_ir[5:0]});
      check("hold_pc4",   pc4,                 exp_pc + 32'd4);
      check("hold_cnt",   inst_cnt,            exp_cnt);
      if (i < wait_cycles) begin
        advance    = 1'b0;
        pcsrc      = 2'($urandom_range(0, 3));
        imem_ack   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        imem_rdata = $urandom;
      end else begin
        advance  = 1'b1;
        pcsrc    = sel;
        imem_ack = 1'b0;
      end
      @(negedge clk);
    end
    advance = 1'b0;
    exp_pc  = model_next(exp_pc, exp_ir, sel);
    exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'd0, imem_req},   32'd0);
    check({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
    check({tag, "_ir"},    inst,                32'd0);
    check({tag, "_cnt"},   inst_cnt,            32'd0);
    check({tag, "_addr"},  imem_addr,           RST_PC);
  endtask

  initial begin
    clrn       = 1'b1;
    pcsrc      = 2'b00;
    advance    = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    exp_pc     = RST_PC;
    exp_ir     = 32'd0;
    exp_cnt    = 32'd0;

    #2 clrn = 1'b0;
    #1 check_reset_outputs("rst_async");
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_held");
    clrn = 1'b1;
    check("idle_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);

    // Back-to-back throughput: immediate ack and immediate advance.
    for (int k = 0; k < 3; k++) begin
      fetch(0, $urandom);
      hold(0, PCSRC_SEQ, 1'b0);
    end
    check("cnt_after_3", inst_cnt, 32'd3);
    check("addr_after_3", imem_addr, 32'd12);

    // Backward branch from 12 lands on 0xFFFF_FFFC, then wraps to 0.
    fetch(1, 32'h1000_FFFB);
    hold(0, PCSRC_BR, 1'b0);
    check("br_back", imem_addr, 32'hFFFF_FFFC);
    fetch(0, $urandom);
    hold(1, PCSRC_RSV, 1'b0);
    check("pc_wrap", imem_addr, 32'd0);

    // Slow memory, then a long stall in HOLD with spurious acks.
    fetch(3, 32'h2001_0005);
    check("op_addi",   {26'd0, op}, 32'h08);
    check("valid_addi", {31'd0, inst_valid}, 32'd1);
    hold(5, PCSRC_SEQ, 1'b1);

    // Jump to 0x100, then branch and jump that both target 0x100.
    fetch(0, 32'h0800_0040);
    hold(0, PCSRC_JMP, 1'b0);
    check("jmp_to_100", imem_addr, 32'h100);
    fetch(1, 32'h1000_FFFF);
    hold(2, PCSRC_BR, 1'b1);
    check("br_to_100", imem_addr, 32'h100);
    fetch(0, 32'h0800_0040);
    hold(1, PCSRC_JMP, 1'b0);
    check("jmp_again_100", imem_addr, 32'h100);

    // Randomized instruction stream.
    for (int k = 0; k < 24; k++) begin
      fetch($urandom_range(0, 3), $urandom);
      hold($urandom_range(0, 3), 2'($urandom_range(0, 3)), 1'b1);
    end

    // Reset mid-FETCH followed by an ack that must be ignored.
    check("pre_rst_req", {31'd0, imem_req}, 32'd1);
    #2 clrn = 1'b0;
    #1 check_reset_outputs("rst_fetch");
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_reset_outputs("rst_late_ack");
    exp_pc  = RST_PC;
    exp_ir  = 32'd0;
    exp_cnt = 32'd0;
    clrn = 1'b1;
    check("rel_idle_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    check("rel_first_addr", imem_addr, RST_PC);
    fetch(0, $urandom);
    hold(0, PCSRC_SEQ, 1'b0);
    check("rel_cnt", inst_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
